// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register file's single write port between the
// ALU writeback path and the LSU load-data path. The grant is combinational
// and the write-port drive is registered, so the write lands one cycle after
// the grant. Writes to x0 are granted but never reach the file.
//
// Build option: define RF_WB_RR_EN to resolve conflicts round-robin. Leave it
// undefined for fixed LSU priority with a MAX_WAIT starvation guard for the ALU.
module rf_wb_arbiter #(
    parameter int MAX_WAIT = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        alu_valid_i,
    input  logic [4:0]  alu_addr_i,
    input  logic [31:0] alu_data_i,
    output logic        alu_ready_o,
    input  logic        lsu_valid_i,
    input  logic [4:0]  lsu_addr_i,
    input  logic [31:0] lsu_data_i,
    output logic        lsu_ready_o,
    output logic        rf_we_o,
    output logic [4:0]  rf_addr_o,
    output logic [31:0] rf_wd_o
);

    logic        alu_grant;
    logic        lsu_grant;
    logic        alu_wins_conflict;

    logic        rf_we_q,   rf_we_d;
    logic [4:0]  rf_addr_q, rf_addr_d;
    logic [31:0] rf_wd_q,   rf_wd_d;

`ifdef RF_WB_RR_EN
    // 1 when the ALU received the most recent grant.
    logic        last_alu_q, last_alu_d;
`else
    localparam logic [3:0] MaxWait = 4'(MAX_WAIT);
    // Consecutive cycles the ALU has been requesting without a grant.
    logic [3:0]  wait_cnt_q, wait_cnt_d;
`endif

    // Decide who takes a conflict cycle under the selected policy.
    always_comb begin
`ifdef RF_WB_RR_EN
        alu_wins_conflict = ~last_alu_q;
`else
        alu_wins_conflict = (wait_cnt_q == MaxWait);
`endif
    end

    // Grant selection; nothing is granted while reset is held.
    always_comb begin
        alu_grant = 1'b0;
        lsu_grant = 1'b0;
        if (!reset_i) begin
            if (alu_valid_i && lsu_valid_i) begin
                alu_grant = alu_wins_conflict;
                lsu_grant = ~alu_wins_conflict;
            end else begin
                alu_grant = alu_valid_i;
                lsu_grant = lsu_valid_i;
            end
        end
    end

    assign alu_ready_o = alu_grant;
    assign lsu_ready_o = lsu_grant;

    // Next-state for the write-port register and the arbitration state.
    always_comb begin
        rf_we_d   = 1'b0;
        rf_addr_d = rf_addr_q;
        rf_wd_d   = rf_wd_q;
        if (alu_grant) begin
            rf_we_d   = (alu_addr_i != 5'd0);
            rf_addr_d = alu_addr_i;
            rf_wd_d   = alu_data_i;
        end else if (lsu_grant) begin
            rf_we_d   = (lsu_addr_i != 5'd0);
            rf_addr_d = lsu_addr_i;
            rf_wd_d   = lsu_data_i;
        end

`ifdef RF_WB_RR_EN
        last_alu_d = last_alu_q;
        if (alu_grant) begin
            last_alu_d = 1'b1;
        end else if (lsu_grant) begin
            last_alu_d = 1'b0;
        end
`else
        wait_cnt_d = wait_cnt_q;
        if (!alu_valid_i || alu_grant) begin
            wait_cnt_d = 4'd0;
        end else if (wait_cnt_q != MaxWait) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
`endif
    end

    // State registers; reset clears the port drive and arbitration history.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rf_we_q    <= 1'b0;
            rf_addr_q  <= 5'd0;
            rf_wd_q    <= 32'd0;
`ifdef RF_WB_RR_EN
            last_alu_q <= 1'b0;
`else
            wait_cnt_q <= 4'd0;
`endif
        end else begin
            rf_we_q    <= rf_we_d;
            rf_addr_q  <= rf_addr_d;
            rf_wd_q    <= rf_wd_d;
`ifdef RF_WB_RR_EN
            last_alu_q <= last_alu_d;
`else
            wait_cnt_q <= wait_cnt_d;
`endif
        end
    end

    // A write still sitting in the output register when reset rises must not
    // reach the file at that same edge, so the enable is masked by reset.
    assign rf_we_o   = rf_we_q & ~reset_i;
    assign rf_addr_o = rf_addr_q;
    assign rf_wd_o   = rf_wd_q;

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-port arbiter for the 32x32 register file. It shares the file's single write port between two writeback requesters: the ALU result path and the load/store unit (LSU) load-data path. A registered output stage drives the file's write-enable, address and data. Writes to x0 are accepted and discarded. A starvation guard bounds how long the ALU can be blocked.

## Interface
- MAX_WAIT, default 4: consecutive lost-arbitration cycles after which the ALU wins the next conflict (fixed-priority mode only); legal range 1..15.

- clk_i  in  1  single clock, all state updates on posedge
- reset_i  in  1  synchronous, active-high reset
- alu_valid_i  in  1  ALU writeback request
- alu_addr_i  in  5  ALU destination register
- alu_data_i  in  32  ALU result
- alu_ready_o  out  1  ALU request granted this cycle
- lsu_valid_i  in  1  LSU writeback request
- lsu_addr_i  in  5  LSU destination register
- lsu_data_i  in  32  load data
- lsu_ready_o  out  1  LSU request granted this cycle
- rf_we_o  out  1  register-file write enable (to WE3)
- rf_addr_o  out  5  register-file write address (to addr_3)
- rf_wd_o  out  32  register-file write data (to WD3)

## Operation
- Handshake: a transfer occurs when valid and ready are both high in the same cycle. A requester holds valid, addr and data stable until its transfer occurs. The ready outputs are combinational from the valid inputs and the arbiter state.
- At most one ready is high per cycle. The arbiter is always able to accept: the output register is rewritten every cycle, so there is no backpressure from the register file.
- Only one requester valid: that requester is granted.
- Both requesters valid (conflict), fixed-priority mode:
  - LSU wins unless wait_cnt == MAX_WAIT, in which case ALU wins.
  - wait_cnt is a 4-bit counter. It increments on each cycle where alu_valid_i=1 and ALU is not granted, saturating at MAX_WAIT.
  - wait_cnt clears on any ALU grant and whenever alu_valid_i=0.
- Output register:
  - On a grant, rf_addr_o and rf_wd_o load the winner's addr and data.
  - rf_we_o loads 1 if the winner's addr != 0, and 0 if addr == 0. An x0 write is accepted (ready high) but never reaches the file.
  - No grant: rf_we_o loads 0; rf_addr_o and rf_wd_o hold.
- Same destination requested by both sources: the writes are serialized in grant order, and the later grant's value remains in the file. Ordering correctness is the issue stage's responsibility.

## Timing
- Grant in cycle N → rf_we_o/rf_addr_o/rf_wd_o valid in cycle N+1 → register file updated at the posedge ending cycle N+1. Latency is 1 cycle from grant to the write-port drive.
- Back-to-back grants allowed every cycle. Sustained conflict gives a worst-case ALU wait of MAX_WAIT cycles.
- Reset (reset_i=1 at a posedge):
  - rf_we_o=0, rf_addr_o=0, rf_wd_o=0, wait_cnt=0, RR pointer=LSU-last.
  - alu_ready_o=0 and lsu_ready_o=0 combinationally while reset_i=1.
  - A grant pending in the output register when reset asserts is dropped: the register-file write does not occur.
- First cycle after reset deasserts: normal arbitration; both-valid resolves per mode.

## Configuration
- RF_WB_RR_EN defined: conflicts are resolved round-robin.
  - A 1-bit last-grant pointer is updated on every grant, and the requester not granted last wins.
  - wait_cnt and MAX_WAIT are unused; wait_cnt stays 0.
  - After reset the pointer marks LSU as last granted, so the first conflict goes to ALU.
- RF_WB_RR_EN undefined: fixed LSU priority with the MAX_WAIT starvation guard, as described above.

## Test plan
- ALU only: alu_valid_i=1, alu_addr_i=5, alu_data_i=0xDEADBEEF → alu_ready_o=1 in the same cycle; next cycle rf_we_o=1, rf_addr_o=5, rf_wd_o=0xDEADBEEF; subsequent read of x5 returns 0xDEADBEEF.
- x0 discard: lsu_valid_i=1, lsu_addr_i=0, lsu_data_i=0x12345678 → lsu_ready_o=1; next cycle rf_we_o=0; a read of x0 returns 0.
- Fixed-priority starvation, MAX_WAIT=4: both valid continuously, with a new LSU request each cycle → LSU granted in cycles 0–3, ALU granted in cycle 4, wait_cnt back to 0 in cycle 5.
- Round-robin (RF_WB_RR_EN): both valid continuously for 4 cycles, starting right after reset → grant sequence ALU, LSU, ALU, LSU.
- Reset mid-operation: grant LSU (addr 7, data 0xA5A5A5A5) in cycle N and assert reset_i in cycle N+1 → rf_we_o=0 after that posedge, both ready outputs low while reset is high, and x7 is unchanged.
- Back-to-back: ALU addr 3 in cycle N, LSU addr 4 in cycle N+1 → rf_we_o high for two consecutive cycles with addresses 3 then 4.
